shift_engine: RTL and testbench

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine_if.sv | 27 ++
 rtl/shift_engine.sv | 75 +++++++
 tb/tb_shift_engine.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/shift_engine_if.sv
// Data and control bundle for shift_engine.
// The bench drives the master side and the engine takes the slave side.
interface shift_engine_if #(
  parameter int N  = 64,
  parameter int CW = 7
);
  logic [N-1:0]  par_in;
  logic          load;
  logic          start;
  logic [2:0]    op;
  logic [CW-1:0] count;
  logic          serin;
  logic [N-1:0]  Data_out;
  logic          serout;
  logic          busy;
  logic          done;

  modport master (
    output par_in, load, start, op, count, serin,
    input  Data_out, serout, busy, done
  );

  modport slave (
    input  par_in, load, start, op, count, serin,
    output Data_out, serout, busy, done
  );
endinterface

// File: rtl/shift_engine.sv
// Multi-cycle shift/rotate engine: one single-bit shift per clock for a latched count.
// state   | meaning
// IDLE    | accepts load (wins) or start; start latches op/count
// SHIFT   | one shift per edge, remaining count decremented; the edge with one left exits
// DONE    | single-cycle completion pulse; load/start ignored
module shift_engine #(
  parameter int N  = 64,
  parameter int CW = 7
) (
  input logic           clock,
  input logic           reset,
  shift_engine_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  data_q;
  logic          serout_q;
  logic [N-1:0]  data_nxt;
  logic          serout_nxt;

  // Single-bit step for the latched op; reserved codes hold data and serout.
  always_comb begin
    data_nxt   = data_q;
    serout_nxt = serout_q;
    case (op_q)
      3'b000: begin data_nxt = {bus.serin, data_q[N-1:1]};     serout_nxt = data_q[0];   end
      3'b001: begin data_nxt = {data_q[N-2:0], bus.serin};     serout_nxt = data_q[N-1]; end
      3'b010: begin data_nxt = {data_q[0], data_q[N-1:1]};     serout_nxt = data_q[0];   end
      3'b011: begin data_nxt = {data_q[N-2:0], data_q[N-1]};   serout_nxt = data_q[N-1]; end
      3'b100: begin data_nxt = {data_q[N-1], data_q[N-1:1]};   serout_nxt = data_q[0];   end
      3'b101: begin data_nxt = {data_q[N-2:0], 1'b0};          serout_nxt = data_q[N-1]; end
      default: begin data_nxt = data_q; serout_nxt = serout_q; end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      serout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.load) begin
            data_q <= bus.par_in;
          end else if (bus.start) begin
            op_q  <= bus.op;
            cnt_q <= bus.count;
            state <= (bus.count != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          data_q   <= data_nxt;
          serout_q <= serout_nxt;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Data_out = data_q;
  assign bus.serout   = serout_q;
  assign bus.busy     = (state == S_SHIFT);
  assign bus.done     = (state == S_DONE);
endmodule

// File: tb/tb_shift_engine.sv
// Randomised and directed check of shift_engine (N=8/CW=4 plus an N=64/CW=7 rotate case).
module tb_shift_engine;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  shift_engine_if #(.N(8),  .CW(4)) b8 ();
  shift_engine_if #(.N(64), .CW(7)) b64 ();

  shift_engine #(.N(8),  .CW(4)) dut8  (.clock(clock), .reset(reset), .bus(b8));
  shift_engine #(.N(64), .CW(7)) dut64 (.clock(clock), .reset(reset), .bus(b64));

  logic [7:0] ref_d  = 8'h00;
  logic       ref_so = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference step written from the operation definitions with plain shift arithmetic.
  function automatic void model_shift(input logic [2:0] o, input logic s);
    logic [7:0] d;
    d = ref_d;
    case (o)
      3'd0: begin ref_d = (d >> 1) | ({7'd0, s} << 7); ref_so = d[0]; end
      3'd1: begin ref_d = (d << 1) | {7'd0, s};        ref_so = d[7]; end
      3'd2: begin ref_d = (d >> 1) | (d << 7);         ref_so = d[0]; end
      3'd3: begin ref_d = (d << 1) | (d >> 7);         ref_so = d[7]; end
      3'd4: begin ref_d = 8'($signed(d) >>> 1);        ref_so = d[0]; end
      3'd5: begin ref_d = d << 1;                      ref_so = d[7]; end
      default: ;
    endcase
  endfunction

  task automatic idle8();
    b8.load = 1'b0; b8.start = 1'b0; b8.par_in = '0;
    b8.op = '0; b8.count = '0; b8.serin = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    b8.load = 1'b1; b8.par_in = v;
    @(negedge clock);
    idle8();
    ref_d = v;
    chk("load_data", 64'(b8.Data_out), 64'(ref_d));
    chk("load_serout", 64'(b8.serout), 64'(ref_so));
    chk("load_busy", 64'(b8.busy), 64'd0);
  endtask

  // sval < 0 selects a random serial fill per shift; noise pulses load/start during SHIFT and DONE.
  task automatic run_op(input logic [2:0] o, input int cnt, input int sval, input bit noise);
    logic s;
    b8.start = 1'b1; b8.op = o; b8.count = 4'(cnt);
    @(negedge clock);
    idle8();
    chk("e0_data", 64'(b8.Data_out), 64'(ref_d));
    chk("e0_busy", 64'(b8.busy), 64'(cnt != 0));
    chk("e0_done", 64'(b8.done), 64'(cnt == 0));
    for (int i = 1; i <= cnt; i++) begin
      s = (sval < 0) ? 1'($urandom_range(0, 1)) : 1'(sval);
      b8.serin = s;
      if (noise) begin
        b8.load   = 1'($urandom_range(0, 1));
        b8.start  = 1'($urandom_range(0, 1));
        b8.par_in = 8'($urandom);
        b8.op     = 3'($urandom);
        b8.count  = 4'($urandom);
      end
      @(negedge clock);
      idle8();
      model_shift(o, s);
      chk("shift_data", 64'(b8.Data_out), 64'(ref_d));
      chk("shift_serout", 64'(b8.serout), 64'(ref_so));
      chk("shift_busy", 64'(b8.busy), 64'(i < cnt));
      chk("shift_done", 64'(b8.done), 64'(i == cnt));
    end
    if (noise) begin
      b8.load = 1'b1; b8.start = 1'b1; b8.par_in = ~ref_d; b8.count = 4'd5;
    end
    @(negedge clock);
    idle8();
    chk("post_data", 64'(b8.Data_out), 64'(ref_d));
    chk("post_busy", 64'(b8.busy), 64'd0);
    chk("post_done", 64'(b8.done), 64'd0);
  endtask

  initial begin
    int busy_cycles;
    bit seen_done;
    logic [63:0] v64;
    idle8();
    b64.load = 1'b0; b64.start = 1'b0; b64.par_in = '0;
    b64.op = '0; b64.count = '0; b64.serin = 1'b0;
    b8.par_in = 8'hFF; b8.load = 1'b1;
    @(negedge clock); @(negedge clock);
    idle8();
    chk("rst_data", 64'(b8.Data_out), 64'd0);
    chk("rst_serout", 64'(b8.serout), 64'd0);
    chk("rst_busy", 64'(b8.busy), 64'd0);
    chk("rst_done", 64'(b8.done), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    do_load(8'hA5); run_op(3'd0, 3, 1, 1'b0);
    chk("a5_final", 64'(b8.Data_out), 64'hF4);
    do_load(8'h81); run_op(3'd3, 8, 0, 1'b0);
    chk("rotl8", 64'(b8.Data_out), 64'h81);
    run_op(3'd3, 1, 0, 1'b0);
    chk("rotl1", 64'(b8.Data_out), 64'h03);
    chk("rotl1_so", 64'(b8.serout), 64'd1);
    do_load(8'h90); run_op(3'd4, 4, 0, 1'b0);
    chk("asr4", 64'(b8.Data_out), 64'hF9);
    run_op(3'd5, 2, 1, 1'b0);
    chk("lzf2", 64'(b8.Data_out), 64'hE4);
    chk("lzf2_so", 64'(b8.serout), 64'd1);
    run_op(3'd2, 0, 0, 1'b1);
    run_op(3'd6, 5, -1, 1'b1);

    b8.load = 1'b1; b8.start = 1'b1; b8.par_in = 8'h3C; b8.count = 4'd4;
    @(negedge clock);
    idle8();
    ref_d = 8'h3C;
    chk("ls_data", 64'(b8.Data_out), 64'h3C);
    chk("ls_busy", 64'(b8.busy), 64'd0);
    @(negedge clock);
    chk("ls_done", 64'(b8.done), 64'd0);

    b8.start = 1'b1; b8.op = 3'd0; b8.count = 4'd10;
    @(negedge clock);
    idle8();
    @(negedge clock); @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_data", 64'(b8.Data_out), 64'd0);
    chk("mid_rst_serout", 64'(b8.serout), 64'd0);
    chk("mid_rst_busy", 64'(b8.busy), 64'd0);
    chk("mid_rst_done", 64'(b8.done), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    ref_d = 8'h00; ref_so = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("after_rst_done", 64'(b8.done), 64'd0);
    end
    do_load(8'h5A); run_op(3'd1, 4, -1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) do_load(8'($urandom));
      else run_op(3'($urandom), int'($urandom_range(0, 15)), -1, 1'($urandom_range(0, 1)));
    end

    v64 = 64'h8000_0000_0000_0001;
    b64.load = 1'b1; b64.par_in = v64;
    @(negedge clock);
    b64.load = 1'b0; b64.par_in = '0;
    b64.start = 1'b1; b64.op = 3'd2; b64.count = 7'd64;
    @(negedge clock);
    b64.start = 1'b0; b64.count = '0;
    busy_cycles = 0; seen_done = 1'b0;
    for (int i = 0; i < 80 && !seen_done; i++) begin
      if (b64.busy) busy_cycles++;
      if (b64.done) seen_done = 1'b1;
      else @(negedge clock);
    end
    chk("n64_done_seen", 64'(seen_done), 64'd1);
    chk("n64_busy_cycles", 64'(busy_cycles), 64'd64);
    chk("n64_data", b64.Data_out, v64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
